// File: rtl/rotate_sequencer.sv
// Sequential rotater: applies one single-bit rotate per clock until the requested
// amount is consumed, then publishes the result and {N,Z,V,C} flags.
module rotate_sequencer #(
  parameter int N       = 8,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dir,
  input  logic [N-1:0]       in_a,
  input  logic [SHIFT_W-1:0] shift,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       out,
  output logic [3:0]         flags_n_z_v_c
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       work_q, work_d;
  logic [SHIFT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [N-1:0]       out_q, out_d;
  logic [3:0]         flags_q, flags_d;

  logic               accept;
  logic [N-1:0]       rotated;

  function automatic logic [N-1:0] rot_step(input logic [N-1:0] w, input logic left);
    if (left) return {w[N-2:0], w[N-1]};
    return {w[0], w[N-1:1]};
  endfunction

  function automatic logic [3:0] calc_flags(input logic [N-1:0] v, input logic c);
    return {v[N-1], (v == '0), 1'b0, c};
  endfunction

  // A new request is taken in DONE as well as IDLE so back-to-back ops have no bubble.
  assign accept  = start && (state_q != RUN);
  assign rotated = rot_step(work_q, dir_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = (shift == '0) ? DONE : RUN;
        else        state_d = IDLE;
      end
      RUN: begin
        if (cnt_q == SHIFT_W'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    out_d   = out_q;
    flags_d = flags_q;
    if (accept) begin
      work_d = in_a;
      cnt_d  = shift;
      dir_d  = dir;
      if (shift == '0) begin
        out_d   = in_a;
        flags_d = calc_flags(in_a, 1'b0);
      end
    end else if (state_q == RUN) begin
      work_d = rotated;
      cnt_d  = cnt_q - SHIFT_W'(1);
      // Carry is the bit that just wrapped around to the other end.
      if (cnt_q == SHIFT_W'(1)) begin
        out_d   = rotated;
        flags_d = calc_flags(rotated, dir_q ? rotated[0] : rotated[N-1]);
      end
    end
  end

  always_comb begin
    busy          = (state_q == RUN);
    done          = (state_q == DONE);
    out           = out_q;
    flags_n_z_v_c = flags_q;
  end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Bench for rotate_sequencer: directed vector table, random ops against an
// arithmetic rotate model, and hand sequences for ignored-start and mid-run reset.
module tb_rotate_sequencer;
  localparam int N  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst, start, dir;
  logic [N-1:0]  in_a;
  logic [SW-1:0] shift;
  logic          busy, done;
  logic [N-1:0]  out;
  logic [3:0]    flags;

  int total = 0;
  int bad   = 0;
  logic [N-1:0] prev_out;
  logic [3:0]   prev_flags;

  typedef struct {
    logic [N-1:0]  a;
    logic          d;
    logic [SW-1:0] s;
    logic [N-1:0]  eo;
    logic [3:0]    ef;
  } vec_t;
  vec_t vt[7];

  always #5 clk = ~clk;

  rotate_sequencer #(.N(N), .SHIFT_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .in_a(in_a), .shift(shift),
    .busy(busy), .done(done), .out(out), .flags_n_z_v_c(flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Rotation by s positions is the same as rotation by s mod N.
  function automatic logic [N-1:0] ref_out(input logic [N-1:0] a, input logic d, input int s);
    int k;
    k = s % N;
    if (k == 0) return a;
    if (d) return (a << k) | (a >> (N - k));
    return (a >> k) | (a << (N - k));
  endfunction

  function automatic logic [3:0] ref_flags(input logic [N-1:0] a, input logic d, input int s);
    logic [N-1:0] r;
    logic c;
    r = ref_out(a, d, s);
    c = (s == 0) ? 1'b0 : (d ? r[0] : r[N-1]);
    return {r[N-1], (r == '0), 1'b0, c};
  endfunction

  // Entered just after a negedge with the DUT in IDLE or DONE; returns at the
  // negedge where done is observed, so a following call is back-to-back.
  task automatic do_op(input string tag, input logic [N-1:0] a, input logic d,
                       input logic [SW-1:0] s, input logic [N-1:0] eo, input logic [3:0] ef);
    int n;
    bit run_ok;
    in_a = a; dir = d; shift = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    run_ok = 1'b1;
    while (!done && n < 40) begin
      if (busy !== 1'b1 || out !== prev_out || flags !== prev_flags) run_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"},  32'(done), 32'd1);
    chk({tag, "_lat"},   32'(n - 1), 32'(s));
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_run"},   32'(run_ok), 32'd1);
    chk({tag, "_out"},   32'(out), 32'(eo));
    chk({tag, "_flags"}, 32'(flags), 32'(ef));
    prev_out   = eo;
    prev_flags = ef;
  endtask

  initial begin
    int n;
    int pulses;
    logic [N-1:0]  ra;
    logic          rd;
    logic [SW-1:0] rs;

    vt[0] = '{8'hF0, 1'b0, 4'd1, 8'h78, 4'h0};
    vt[1] = '{8'hF0, 1'b0, 4'd3, 8'h1E, 4'h0};
    vt[2] = '{8'hF0, 1'b0, 4'd6, 8'hC3, 4'h9};
    vt[3] = '{8'hF0, 1'b0, 4'd9, 8'h78, 4'h0};
    vt[4] = '{8'hF0, 1'b0, 4'd0, 8'hF0, 4'h8};
    vt[5] = '{8'h81, 1'b1, 4'd1, 8'h03, 4'h1};
    vt[6] = '{8'h00, 1'b1, 4'd5, 8'h00, 4'h4};

    rst = 1'b1; start = 1'b0; dir = 1'b0; in_a = '0; shift = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_out",   32'(out), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    prev_out = '0;
    prev_flags = '0;

    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vt[i].a, vt[i].d, vt[i].s, vt[i].eo, vt[i].ef);
    @(negedge clk);
    chk("vec_done_pulse", 32'(done), 32'd0);
    chk("vec_hold_out",   32'(out), 32'(prev_out));

    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom);
      rd = 1'($urandom);
      rs = SW'($urandom_range(0, 15));
      do_op($sformatf("rnd%0d", i), ra, rd, rs, ref_out(ra, rd, int'(rs)), ref_flags(ra, rd, int'(rs)));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk("rnd_idle_done", 32'(done), 32'd0);
        chk("rnd_idle_busy", 32'(busy), 32'd0);
        chk("rnd_idle_hold", 32'({out, flags}), 32'({prev_out, prev_flags}));
      end
    end
    @(negedge clk);

    // A start pulse during RUN must be ignored.
    in_a = 8'h5A; dir = 1'b0; shift = 4'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    start = 1'b0;
    while (!done && n < 40) begin
      if (n == 2) begin
        start = 1'b1; in_a = 8'hFF; dir = 1'b1; shift = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("ign_lat",   32'(n - 1), 32'd7);
    chk("ign_out",   32'(out), 32'(ref_out(8'h5A, 1'b0, 7)));
    chk("ign_const", 32'(out), 32'hB4);
    chk("ign_flags", 32'(flags), 32'(ref_flags(8'h5A, 1'b0, 7)));
    @(negedge clk);
    chk("ign_after_done", 32'(done), 32'd0);
    chk("ign_after_busy", 32'(busy), 32'd0);

    // Reset in the third RUN cycle aborts with no done pulse.
    in_a = 8'hF0; dir = 1'b1; shift = 4'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_done",  32'(done), 32'd0);
    chk("abort_out",   32'(out), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
